// File: rtl/posit_pkg.sv
// posit_pkg: shared posit widths, constants, FSM state type and operand decode.
package posit_pkg;

  function automatic int unsigned posit_rs(input int unsigned n);
    return $clog2(n);
  endfunction

  localparam int unsigned PN  = 32;
  localparam int unsigned PES = 4;
  localparam int unsigned PMW = PN - PES - 2;
  localparam int unsigned PSW = posit_rs(PN) + PES + 3;

  localparam logic [PN-1:0] NAR    = {1'b1, {(PN-1){1'b0}}};
  localparam logic [PN-1:0] ZERO   = '0;
  localparam logic [PN-1:0] MAXPOS = {1'b0, {(PN-1){1'b1}}};
  localparam logic [PN-1:0] MINPOS = {{(PN-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_MUL,
    ST_ROUND,
    ST_DONE
  } posit_mul_state_t;

  typedef struct packed {
    logic                  sign;
    logic signed [PSW-1:0] scale;
    logic [PMW-1:0]        sig;
    logic                  is_nar;
    logic                  is_zero;
  } posit_dec_t;

  // Split a posit into sign, scale (k*2^ES + e) and significand 1.f left-aligned.
  function automatic posit_dec_t posit_decode(input logic [PN-1:0] p);
    posit_dec_t    d;
    logic [PN-2:0] a;
    logic          r0;
    logic          run;
    int unsigned   m;
    int            k;
    logic [PN-4:0] body;
    d.is_nar  = (p == NAR);
    d.is_zero = (p == ZERO);
    d.sign    = p[PN-1];
    // Low N-1 bits of the two's complement of p
    a   = (p[PN-2:0] ^ {(PN-1){p[PN-1]}}) + {{(PN-2){1'b0}}, p[PN-1]};
    r0  = a[PN-2];
    run = 1'b1;
    m   = 0;
    for (int unsigned i = 0; i < PN - 1; i++) begin
      if (run && (a[PN-2-i] == r0)) m = m + 1;
      else run = 1'b0;
    end
    // Drop regime run plus terminator; a[PN-2:PN-3] always belong to the regime
    body    = a[PN-4:0] << (m - 1);
    k       = r0 ? (int'(m) - 1) : -int'(m);
    d.scale = PSW'(k * int'(2**PES) + int'(body[PN-4 -: PES]));
    d.sig   = {1'b1, body[PN-4-PES:0]};
    return d;
  endfunction

endpackage

// File: rtl/posit_encode.sv
// posit_encode: {sign, scale, raw product significand} -> rounded, saturated posit.
module posit_encode
  import posit_pkg::*;
#(
  parameter int unsigned N  = PN,
  parameter int unsigned ES = PES,
  parameter int unsigned MW = N - ES - 2,
  parameter int unsigned SW = posit_rs(N) + ES + 3
) (
  input  logic                 sign,
  input  logic signed [SW-1:0] scale,
  input  logic [2*MW-1:0]      sig,
  output logic [N-1:0]         result
);
  localparam int unsigned FW = 2 * MW - 1;
  localparam int unsigned KW = SW - ES;
  localparam int unsigned VW = 2 + ES + FW + N;
  localparam logic signed [KW-1:0] K_SAT_HI = KW'(N - 2);
  localparam logic signed [KW-1:0] K_SAT_LO = KW'(-(int'(N) - 2));

  logic signed [SW-1:0] s_adj;
  logic [FW-1:0]        frac;
  logic signed [KW-1:0] k;
  logic [ES-1:0]        e;
  int                   amt;
  logic [VW-1:0]        vec;
  logic [N-2:0]         body;
  logic                 guard;
  logic                 sticky;
  logic [N-2:0]         mag;

  // Normalise to [1,2), build regime/exponent/fraction string, round RNE, saturate, apply sign
  always_comb begin
    s_adj = scale + $signed({{(SW-1){1'b0}}, sig[2*MW-1]});
    frac  = sig[2*MW-1] ? sig[2*MW-2:0] : {sig[2*MW-3:0], 1'b0};
    k     = s_adj[SW-1:ES];
    e     = s_adj[ES-1:0];
    amt   = k[KW-1] ? (-int'(k) - 1) : int'(k);
    // Positive k: arithmetic shift of "10" replicates the ones of the regime run.
    // Negative k: logical shift of "01" supplies the zeros of the run.
    if (k[KW-1]) vec = {2'b01, e, frac, {N{1'b0}}} >> amt;
    else         vec = $unsigned($signed({2'b10, e, frac, {N{1'b0}}}) >>> amt);
    body   = vec[VW-1 -: N-1];
    guard  = vec[VW-N];
    sticky = |vec[VW-N-1:0];
    mag    = body + {{(N-2){1'b0}}, guard & (sticky | body[0])};
    if (k >= K_SAT_HI)     mag = MAXPOS[N-2:0];
    else if (k < K_SAT_LO) mag = MINPOS[N-2:0];
    result = sign ? ('0 - {1'b0, mag}) : {1'b0, mag};
  end

endmodule

// File: rtl/posit_mul_seq.sv
// posit_mul_seq: multi-cycle posit multiplier, one significand bit per cycle.
module posit_mul_seq
  import posit_pkg::*;
#(
  parameter int unsigned N  = PN,
  parameter int unsigned ES = PES,
  parameter int unsigned MW = N - ES - 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] IN1,
  input  logic [N-1:0] IN2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] OUT
);
  localparam int unsigned SW = posit_rs(N) + ES + 3;
  localparam int unsigned CW = $clog2(MW);

  posit_mul_state_t     state_q;
  posit_mul_state_t     state_d;
  logic [N-1:0]         in1_q;
  logic [N-1:0]         in2_q;
  posit_dec_t           d1;
  posit_dec_t           d2;
  logic                 special;
  logic                 sign_q;
  logic signed [SW-1:0] scale_q;
  logic [2*MW-1:0]      mcand_q;
  logic [MW-1:0]        mplier_q;
  logic [2*MW-1:0]      acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 mul_last;
  logic [N-1:0]         out_q;
  logic [N-1:0]         enc_out;

  // Decode both registered operands
  always_comb begin
    d1       = posit_decode(in1_q);
    d2       = posit_decode(in2_q);
    special  = d1.is_nar | d2.is_nar | d1.is_zero | d2.is_zero;
    mul_last = (cnt_q == CW'(MW - 1));
  end

  posit_encode #(
    .N (N),
    .ES(ES),
    .MW(MW),
    .SW(SW)
  ) u_encode (
    .sign  (sign_q),
    .scale (scale_q),
    .sig   (acc_q),
    .result(enc_out)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (in_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = special ? ST_DONE : ST_MUL;
      ST_MUL:    if (mul_last) state_d = ST_ROUND;
      ST_ROUND:  state_d = ST_DONE;
      ST_DONE:   if (out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    OUT       = out_q;
  end

  // Datapath: operand capture, special results, shift-add, rounded result
  always_ff @(posedge clk) begin
    if (rst) begin
      in1_q    <= '0;
      in2_q    <= '0;
      sign_q   <= 1'b0;
      scale_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in1_q <= IN1;
            in2_q <= IN2;
          end
        end
        ST_DECODE: begin
          sign_q   <= d1.sign ^ d2.sign;
          scale_q  <= d1.scale + d2.scale;
          mcand_q  <= {{MW{1'b0}}, d1.sig};
          mplier_q <= d2.sig;
          acc_q    <= '0;
          cnt_q    <= '0;
          if (d1.is_nar || d2.is_nar)       out_q <= NAR;
          else if (d1.is_zero || d2.is_zero) out_q <= ZERO;
        end
        ST_MUL: begin
          // Multiplier shifts right and multiplicand left each cycle, so testing
          // bit 0 and adding mcand_q equals testing bit[cnt] and adding mcand<<cnt.
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mplier_q <= mplier_q >> 1;
          mcand_q  <= mcand_q << 1;
          cnt_q    <= cnt_q + 1'b1;
        end
        ST_ROUND: out_q <= enc_out;
        default: ;
      endcase
    end
  end

endmodule
